// File: rtl/irq_trap_if.sv
// Core <-> trap controller bundle: interrupt sources, exception report,
// trap handshake and the captured CSR values.
interface irq_trap_if #(
  parameter int XLEN = 32,
  parameter int NIRQ = 8
);
  logic [XLEN-1:0] pc;
  logic            mstatus_mie;
  logic [XLEN-1:0] mie;
  logic [NIRQ-1:0] irq;
  logic            timer_irq;
  logic            sw_irq;
  logic            exc_valid;
  logic [4:0]      exc_cause;
  logic [XLEN-1:0] exc_tval;
  logic            mret;
  logic            trap_ack;
  logic [NIRQ-1:0] irq_clear;
  logic            trap_req;
  logic            in_trap;
  logic [XLEN-1:0] mip;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mtval;

  modport master (
    output pc, mstatus_mie, mie, irq, timer_irq, sw_irq, exc_valid, exc_cause,
           exc_tval, mret, trap_ack, irq_clear,
    input  trap_req, in_trap, mip, mcause, mepc, mtval
  );

  modport slave (
    input  pc, mstatus_mie, mie, irq, timer_irq, sw_irq, exc_valid, exc_cause,
           exc_tval, mret, trap_ack, irq_clear,
    output trap_req, in_trap, mip, mcause, mepc, mtval
  );
endinterface

// File: rtl/irq_trap_ctrl.sv
// Machine-mode trap controller: pending-interrupt tracking, fixed-priority
// arbitration and the mepc/mcause/mtval capture handshake with the core.
module irq_trap_ctrl #(
  parameter int              XLEN      = 32,
  parameter int              NIRQ      = 8,
  parameter logic [NIRQ-1:0] EDGE_MASK = '0
) (
  input logic       clk,
  input logic       reset,
  irq_trap_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_t;

  state_t          state, state_nxt;
  logic [NIRQ-1:0] irq_prev, plat_pend, plat_nxt, sel, rise;
  logic            armed, sw_q, tmr_q;
  logic [XLEN-1:0] pend, act;
  logic [4:0]      irq_code;
  logic            exc_take, irq_take;

  always_comb begin
    pend = '0;
    pend[3] = sw_q;
    pend[7] = tmr_q;
    pend[16 +: NIRQ] = plat_pend;
  end

  assign act = pend & bus.mie;

  // Lowest-priority sources first so higher ones overwrite: MTI, MSI, then lines high->low.
  always_comb begin
    irq_code = 5'd0;
    sel = '0;
    if (act[7]) irq_code = 5'd7;
    if (act[3]) irq_code = 5'd3;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (act[16 + i]) begin
        irq_code = 5'(16 + i);
        sel = '0;
        sel[i] = 1'b1;
      end
    end
  end

  assign irq_take = (state == IDLE) & bus.mstatus_mie & (|act) & ~bus.exc_valid;
  assign exc_take = bus.exc_valid & (state != REQ);

  // armed blocks edge detection in the first cycle out of reset, when irq_prev is not yet valid.
  assign rise = armed ? (bus.irq & ~irq_prev) : '0;

  always_comb begin
    plat_nxt = '0;
    for (int i = 0; i < NIRQ; i++) begin
      plat_nxt[i] = EDGE_MASK[i]
                  ? (rise[i] | (plat_pend[i] & ~bus.irq_clear[i] & ~(irq_take & sel[i])))
                  : bus.irq[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (exc_take || irq_take) state_nxt = REQ;
      REQ:     if (bus.trap_ack) state_nxt = HANDLER;
      HANDLER: if (exc_take) state_nxt = REQ;
               else if (bus.mret) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev   <= '0;
      armed      <= 1'b0;
      sw_q       <= 1'b0;
      tmr_q      <= 1'b0;
      plat_pend  <= '0;
      bus.mepc   <= '0;
      bus.mcause <= '0;
      bus.mtval  <= '0;
    end else begin
      irq_prev  <= bus.irq;
      armed     <= 1'b1;
      sw_q      <= bus.sw_irq;
      tmr_q     <= bus.timer_irq;
      plat_pend <= plat_nxt;
      if (exc_take) begin
        bus.mepc   <= bus.pc;
        bus.mcause <= {{(XLEN-5){1'b0}}, bus.exc_cause};
        bus.mtval  <= bus.exc_tval;
      end else if (irq_take) begin
        bus.mepc   <= bus.pc;
        bus.mcause <= {1'b1, {(XLEN-6){1'b0}}, irq_code};
        bus.mtval  <= '0;
      end
    end
  end

  assign bus.trap_req = (state == REQ);
  assign bus.in_trap  = (state != IDLE);
  assign bus.mip      = pend;
endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Bench for irq_trap_ctrl: priority table, directed corner sequences and a
// randomized run checked every cycle against a cause-list reference model.
module tb_irq_trap_ctrl;
  localparam int XLEN = 32;
  localparam int NIRQ = 8;
  localparam logic [NIRQ-1:0] EMASK = 8'b0000_0010;

  logic clk = 1'b0;
  logic reset;

  irq_trap_if #(.XLEN(XLEN), .NIRQ(NIRQ)) bus ();

  irq_trap_ctrl #(.XLEN(XLEN), .NIRQ(NIRQ), .EDGE_MASK(EMASK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = idle, 1 = waiting for ack, 2 = in handler
  int            m_st;
  bit [NIRQ-1:0] m_lvl, m_epend, m_prev;
  bit            m_first, m_sw, m_tmr;
  bit [31:0]     m_cause, m_epc, m_tval;

  typedef struct {
    logic [7:0]  irq;
    logic        sw;
    logic        tmr;
    logic [31:0] mie;
    logic [31:0] pc;
    logic [31:0] cause;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
    end
  endtask

  function automatic bit [31:0] m_mip();
    bit [31:0] v = '0;
    v[3] = m_sw;
    v[7] = m_tmr;
    for (int i = 0; i < NIRQ; i++) v[16 + i] = EMASK[i] ? m_epend[i] : m_lvl[i];
    return v;
  endfunction

  task automatic model_step();
    bit [31:0] a;
    int        code;
    bit        exc, intr, rise, clr;
    int        ord[$];
    if (reset) begin
      m_st = 0; m_lvl = '0; m_epend = '0; m_prev = '0; m_first = 1'b1;
      m_sw = 1'b0; m_tmr = 1'b0; m_cause = '0; m_epc = '0; m_tval = '0;
      return;
    end
    a = m_mip() & bus.mie;
    for (int i = 0; i < NIRQ; i++) ord.push_back(16 + i);
    ord.push_back(3);
    ord.push_back(7);
    code = -1;
    foreach (ord[k]) if (code < 0 && a[ord[k]]) code = ord[k];
    exc  = bus.exc_valid && m_st != 1;
    intr = !bus.exc_valid && m_st == 0 && bus.mstatus_mie && code >= 0;
    if (exc) begin
      m_epc = bus.pc; m_cause = {27'd0, bus.exc_cause}; m_tval = bus.exc_tval;
    end else if (intr) begin
      m_epc = bus.pc; m_cause = 32'h8000_0000 | 32'(code); m_tval = '0;
    end
    for (int i = 0; i < NIRQ; i++) begin
      if (EMASK[i]) begin
        rise = !m_first && bus.irq[i] && !m_prev[i];
        clr  = bus.irq_clear[i] || (intr && code == 16 + i);
        if (rise) m_epend[i] = 1'b1;
        else if (clr) m_epend[i] = 1'b0;
      end
    end
    m_lvl = bus.irq; m_prev = bus.irq; m_first = 1'b0;
    m_sw = bus.sw_irq; m_tmr = bus.timer_irq;
    case (m_st)
      0: if (exc || intr) m_st = 1;
      1: if (bus.trap_ack) m_st = 2;
      default: if (exc) m_st = 1; else if (bus.mret) m_st = 0;
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_trap_req", 32'(bus.trap_req), 32'(m_st == 1));
    chk("model_in_trap", 32'(bus.in_trap), 32'(m_st != 0));
    chk("model_mip", bus.mip, m_mip());
    chk("model_mcause", bus.mcause, m_cause);
    chk("model_mepc", bus.mepc, m_epc);
    chk("model_mtval", bus.mtval, m_tval);
  endtask

  task automatic clr_in();
    bus.pc = '0; bus.mstatus_mie = 1'b0; bus.mie = '0; bus.irq = '0;
    bus.timer_irq = 1'b0; bus.sw_irq = 1'b0; bus.exc_valid = 1'b0;
    bus.exc_cause = '0; bus.exc_tval = '0; bus.mret = 1'b0;
    bus.trap_ack = 1'b0; bus.irq_clear = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_in();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic service();
    bus.trap_ack = 1'b1; tick(); bus.trap_ack = 1'b0;
    bus.mret = 1'b1; tick(); bus.mret = 1'b0;
  endtask

  initial begin
    tbl[0] = '{8'h00, 1'b0, 1'b1, 32'h0000_0080, 32'h0000_0100, 32'h8000_0007};
    tbl[1] = '{8'h04, 1'b1, 1'b1, 32'h00FF_0088, 32'h0000_0104, 32'h8000_0012};
    tbl[2] = '{8'h00, 1'b1, 1'b1, 32'h0000_0088, 32'h0000_0108, 32'h8000_0003};
    tbl[3] = '{8'h81, 1'b1, 1'b0, 32'h0080_0008, 32'h0000_010C, 32'h8000_0017};
    tbl[4] = '{8'h01, 1'b1, 1'b1, 32'h0001_0088, 32'h0000_0110, 32'h8000_0010};
    tbl[5] = '{8'h20, 1'b0, 1'b1, 32'h0020_0000, 32'h0000_0114, 32'h8000_0015};

    reset = 1'b1;
    clr_in();
    tick();
    chk("reset_trap_req", 32'(bus.trap_req), 32'd0);
    chk("reset_in_trap", 32'(bus.in_trap), 32'd0);
    chk("reset_mip", bus.mip, 32'd0);
    chk("reset_mcause", bus.mcause, 32'd0);
    do_reset();

    // Source/enable combinations: one trap round each
    foreach (tbl[k]) begin
      do_reset();
      bus.irq = tbl[k].irq; bus.sw_irq = tbl[k].sw; bus.timer_irq = tbl[k].tmr;
      bus.mie = tbl[k].mie; bus.pc = tbl[k].pc; bus.mstatus_mie = 1'b1;
      tick();
      chk("tbl_no_req_yet", 32'(bus.trap_req), 32'd0);
      tick();
      chk("tbl_trap_req", 32'(bus.trap_req), 32'd1);
      chk("tbl_mcause", bus.mcause, tbl[k].cause);
      chk("tbl_mepc", bus.mepc, tbl[k].pc);
      chk("tbl_mtval", bus.mtval, 32'd0);
      bus.trap_ack = 1'b1; tick(); bus.trap_ack = 1'b0;
      chk("tbl_ack_in_trap", 32'(bus.in_trap), 32'd1);
      chk("tbl_ack_req_low", 32'(bus.trap_req), 32'd0);
      bus.irq = '0; bus.sw_irq = 1'b0; bus.timer_irq = 1'b0;
      bus.mret = 1'b1; tick(); bus.mret = 1'b0;
      chk("tbl_mret_idle", 32'(bus.in_trap), 32'd0);
      chk("tbl_mret_hold", bus.mcause, tbl[k].cause);
    end

    // Priority rounds: line 2, then MSI, then MTI
    do_reset();
    bus.irq = 8'h04; bus.sw_irq = 1'b1; bus.timer_irq = 1'b1;
    bus.mie = 32'h0004_0088; bus.mstatus_mie = 1'b1; bus.pc = 32'h40;
    tick(); tick();
    chk("prio_1", bus.mcause, 32'h8000_0012);
    bus.irq = '0; service(); tick();
    chk("prio_2", bus.mcause, 32'h8000_0003);
    bus.sw_irq = 1'b0; service(); tick();
    chk("prio_3", bus.mcause, 32'h8000_0007);
    bus.timer_irq = 1'b0; service();

    // Exception beats an eligible interrupt; stale interrupt re-taken after mret
    do_reset();
    bus.mie = 32'h0001_0000; bus.mstatus_mie = 1'b1; bus.irq = 8'h01; bus.pc = 32'h200;
    tick();
    bus.exc_valid = 1'b1; bus.exc_cause = 5'd4; bus.exc_tval = 32'h203;
    tick();
    chk("exc_trap_req", 32'(bus.trap_req), 32'd1);
    chk("exc_mcause", bus.mcause, 32'd4);
    chk("exc_mtval", bus.mtval, 32'h203);
    chk("exc_mepc", bus.mepc, 32'h200);
    bus.exc_cause = 5'd5; bus.exc_tval = 32'h999; bus.pc = 32'h204;
    tick();
    bus.exc_valid = 1'b0;
    chk("req_ignore_exc", bus.mcause, 32'd4);
    chk("req_stable_mepc", bus.mepc, 32'h200);
    bus.trap_ack = 1'b1; tick(); bus.trap_ack = 1'b0;
    bus.mret = 1'b1; tick(); bus.mret = 1'b0;
    chk("mret_no_req", 32'(bus.trap_req), 32'd0);
    chk("mret_hold_mtval", bus.mtval, 32'h203);
    tick();
    chk("retake_req", 32'(bus.trap_req), 32'd1);
    chk("retake_mcause", bus.mcause, 32'h8000_0010);
    bus.irq = '0;
    bus.trap_ack = 1'b1; tick();
    tick(); bus.trap_ack = 1'b0;
    chk("hndl_ack_ignored", 32'(bus.in_trap), 32'd1);
    chk("hndl_ack_no_req", 32'(bus.trap_req), 32'd0);
    chk("hndl_ack_cause", bus.mcause, 32'h8000_0010);
    bus.mret = 1'b1; bus.exc_valid = 1'b1; bus.exc_cause = 5'd5; bus.exc_tval = 32'h44;
    tick();
    bus.mret = 1'b0; bus.exc_valid = 1'b0;
    chk("mret_exc_req", 32'(bus.trap_req), 32'd1);
    chk("mret_exc_cause", bus.mcause, 32'd5);
    service();
    bus.mret = 1'b1; tick(); bus.mret = 1'b0;
    chk("idle_mret_in_trap", 32'(bus.in_trap), 32'd0);
    chk("idle_mret_cause", bus.mcause, 32'd5);

    // Edge-triggered line 1
    do_reset();
    bus.mie = 32'h0002_0000;
    bus.irq = 8'h02; tick(); bus.irq = 8'h00; tick(); tick();
    chk("edge_pending", 32'(bus.mip[17]), 32'd1);
    chk("edge_masked", 32'(bus.trap_req), 32'd0);
    bus.mstatus_mie = 1'b1; tick();
    chk("edge_taken", bus.mcause, 32'h8000_0011);
    chk("edge_cleared", 32'(bus.mip[17]), 32'd0);
    bus.trap_ack = 1'b1; tick(); bus.trap_ack = 1'b0;
    bus.irq = 8'h02; bus.irq_clear = 8'h02; tick();
    bus.irq_clear = 8'h00;
    chk("edge_beats_clear", 32'(bus.mip[17]), 32'd1);
    tick();
    bus.irq_clear = 8'h02; tick(); bus.irq_clear = 8'h00;
    chk("edge_sw_clear", 32'(bus.mip[17]), 32'd0);
    bus.irq = '0; bus.mret = 1'b1; tick(); bus.mret = 1'b0;

    // Reset while trap_req is high, with an edge line held high across it
    do_reset();
    bus.timer_irq = 1'b1; bus.mie = 32'h80; bus.mstatus_mie = 1'b1; bus.pc = 32'h300;
    tick(); tick();
    chk("pre_rst_req", 32'(bus.trap_req), 32'd1);
    reset = 1'b1; bus.timer_irq = 1'b0; bus.irq = 8'h02; bus.mie = 32'h0002_0000;
    tick();
    chk("rst_trap_req", 32'(bus.trap_req), 32'd0);
    chk("rst_in_trap", 32'(bus.in_trap), 32'd0);
    chk("rst_mcause", bus.mcause, 32'd0);
    chk("rst_mepc", bus.mepc, 32'd0);
    reset = 1'b0;
    tick(); tick();
    chk("rst_no_edge", 32'(bus.mip[17]), 32'd0);
    chk("rst_no_req", 32'(bus.trap_req), 32'd0);

    // Randomized traffic against the model
    do_reset();
    bus.mie = 32'h00FF_0088;
    for (int n = 0; n < 3000; n++) begin
      int b;
      bus.pc = $urandom;
      bus.mstatus_mie = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) bus.mie = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        b = $urandom_range(0, NIRQ - 1);
        bus.irq[b] = ~bus.irq[b];
      end
      if ($urandom_range(0, 7) == 0) bus.sw_irq = ~bus.sw_irq;
      if ($urandom_range(0, 7) == 0) bus.timer_irq = ~bus.timer_irq;
      bus.exc_valid = ($urandom_range(0, 9) == 0);
      bus.exc_cause = 5'($urandom);
      bus.exc_tval  = $urandom;
      bus.trap_ack  = ($urandom_range(0, 2) == 0);
      bus.mret      = ($urandom_range(0, 3) == 0);
      bus.irq_clear = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
